// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, ALU operand selection
// and load-use hazard detection for the decode stage.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic [REGW-1:0]  rs_d,
  input  logic [REGW-1:0]  rt_d,
  input  logic [REGW-1:0]  rd_d,
  input  logic [2:0]       alucontrol_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic             branch_d,
  input  logic [WIDTH-1:0] aluout_m,
  input  logic [REGW-1:0]  writereg_m,
  input  logic             regwrite_m,
  input  logic [WIDTH-1:0] result_w,
  input  logic [REGW-1:0]  writereg_w,
  input  logic             regwrite_w,
  output logic [WIDTH-1:0] srca_e,
  output logic [WIDTH-1:0] srcb_e,
  output logic [2:0]       alucontrol_e,
  output logic [WIDTH-1:0] writedata_e,
  output logic [REGW-1:0]  writereg_e,
  output logic             valid_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic             memwrite_e,
  output logic             branch_e,
  output logic             lwstall
);

  logic             valid_e_q,      valid_e_d;
  logic [WIDTH-1:0] rd1_e_q,        rd1_e_d;
  logic [WIDTH-1:0] rd2_e_q,        rd2_e_d;
  logic [WIDTH-1:0] signimm_e_q,    signimm_e_d;
  logic [REGW-1:0]  rs_e_q,         rs_e_d;
  logic [REGW-1:0]  rt_e_q,         rt_e_d;
  logic [REGW-1:0]  rd_e_q,         rd_e_d;
  logic [2:0]       alucontrol_e_q, alucontrol_e_d;
  logic             alusrc_e_q,     alusrc_e_d;
  logic             regdst_e_q,     regdst_e_d;
  logic             regwrite_e_q,   regwrite_e_d;
  logic             memtoreg_e_q,   memtoreg_e_d;
  logic             memwrite_e_q,   memwrite_e_d;
  logic             branch_e_q,     branch_e_d;

  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [REGW-1:0]  writereg_sel;

  // Next-state: flush beats stall, stall beats load.
  always_comb begin
    valid_e_d      = valid_e_q;
    rd1_e_d        = rd1_e_q;
    rd2_e_d        = rd2_e_q;
    signimm_e_d    = signimm_e_q;
    rs_e_d         = rs_e_q;
    rt_e_d         = rt_e_q;
    rd_e_d         = rd_e_q;
    alucontrol_e_d = alucontrol_e_q;
    alusrc_e_d     = alusrc_e_q;
    regdst_e_d     = regdst_e_q;
    regwrite_e_d   = regwrite_e_q;
    memtoreg_e_d   = memtoreg_e_q;
    memwrite_e_d   = memwrite_e_q;
    branch_e_d     = branch_e_q;
    if (flush_e) begin
      valid_e_d      = 1'b0;
      rd1_e_d        = '0;
      rd2_e_d        = '0;
      signimm_e_d    = '0;
      rs_e_d         = '0;
      rt_e_d         = '0;
      rd_e_d         = '0;
      alucontrol_e_d = 3'b000;
      alusrc_e_d     = 1'b0;
      regdst_e_d     = 1'b0;
      regwrite_e_d   = 1'b0;
      memtoreg_e_d   = 1'b0;
      memwrite_e_d   = 1'b0;
      branch_e_d     = 1'b0;
    end else if (!stall_e) begin
      valid_e_d      = valid_d;
      rd1_e_d        = rd1_d;
      rd2_e_d        = rd2_d;
      signimm_e_d    = signimm_d;
      rs_e_d         = rs_d;
      rt_e_d         = rt_d;
      rd_e_d         = rd_d;
      alucontrol_e_d = alucontrol_d;
      alusrc_e_d     = alusrc_d;
      regdst_e_d     = regdst_d;
      regwrite_e_d   = regwrite_d;
      memtoreg_e_d   = memtoreg_d;
      memwrite_e_d   = memwrite_d;
      branch_e_d     = branch_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_e_q      <= 1'b0;
      rd1_e_q        <= '0;
      rd2_e_q        <= '0;
      signimm_e_q    <= '0;
      rs_e_q         <= '0;
      rt_e_q         <= '0;
      rd_e_q         <= '0;
      alucontrol_e_q <= 3'b000;
      alusrc_e_q     <= 1'b0;
      regdst_e_q     <= 1'b0;
      regwrite_e_q   <= 1'b0;
      memtoreg_e_q   <= 1'b0;
      memwrite_e_q   <= 1'b0;
      branch_e_q     <= 1'b0;
    end else begin
      valid_e_q      <= valid_e_d;
      rd1_e_q        <= rd1_e_d;
      rd2_e_q        <= rd2_e_d;
      signimm_e_q    <= signimm_e_d;
      rs_e_q         <= rs_e_d;
      rt_e_q         <= rt_e_d;
      rd_e_q         <= rd_e_d;
      alucontrol_e_q <= alucontrol_e_d;
      alusrc_e_q     <= alusrc_e_d;
      regdst_e_q     <= regdst_e_d;
      regwrite_e_q   <= regwrite_e_d;
      memtoreg_e_q   <= memtoreg_e_d;
      memwrite_e_q   <= memwrite_e_d;
      branch_e_q     <= branch_e_d;
    end
  end

  // MEM is the younger producer, so it wins over WB; r0 is never forwarded.
  always_comb begin
    fwd_a = rd1_e_q;
    if (regwrite_m && (writereg_m != '0) && (writereg_m == rs_e_q))
      fwd_a = aluout_m;
    else if (regwrite_w && (writereg_w != '0) && (writereg_w == rs_e_q))
      fwd_a = result_w;

    fwd_b = rd2_e_q;
    if (regwrite_m && (writereg_m != '0) && (writereg_m == rt_e_q))
      fwd_b = aluout_m;
    else if (regwrite_w && (writereg_w != '0) && (writereg_w == rt_e_q))
      fwd_b = result_w;
  end

  always_comb begin
    writereg_sel = regdst_e_q ? rd_e_q : rt_e_q;
  end

  assign srca_e       = fwd_a;
  assign writedata_e  = fwd_b;
  assign srcb_e       = alusrc_e_q ? signimm_e_q : fwd_b;
  assign writereg_e   = writereg_sel;
  assign alucontrol_e = alucontrol_e_q;
  assign valid_e      = valid_e_q;
  assign regwrite_e   = regwrite_e_q;
  assign memtoreg_e   = memtoreg_e_q;
  assign memwrite_e   = memwrite_e_q;
  assign branch_e     = branch_e_q;

  // A load in E cannot forward its data in time for a dependent op in decode.
  assign lwstall = valid_e_q && memtoreg_e_q && regwrite_e_q && (writereg_sel != '0) &&
                   valid_d && ((rs_d == writereg_sel) || (rt_d == writereg_sel));

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_e, flush_e, valid_d;
  logic [31:0] rd1_d, rd2_d, signimm_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [2:0]  alucontrol_d;
  logic        alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d, branch_d;
  logic [31:0] aluout_m, result_w;
  logic [4:0]  writereg_m, writereg_w;
  logic        regwrite_m, regwrite_w;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  writereg_e;
  logic        valid_e, regwrite_e, memtoreg_e, memwrite_e, branch_e, lwstall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .regdst_d(regdst_d), .regwrite_d(regwrite_d),
    .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d), .branch_d(branch_d),
    .aluout_m(aluout_m), .writereg_m(writereg_m), .regwrite_m(regwrite_m),
    .result_w(result_w), .writereg_w(writereg_w), .regwrite_w(regwrite_w),
    .srca_e(srca_e), .srcb_e(srcb_e), .alucontrol_e(alucontrol_e),
    .writedata_e(writedata_e), .writereg_e(writereg_e), .valid_e(valid_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
    .branch_e(branch_e), .lwstall(lwstall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall_e = 0; flush_e = 0;
    valid_d = 1; rd1_d = 32'h11; rd2_d = 32'h22; signimm_d = 32'h33;
    rs_d = 5'd1; rt_d = 5'd2; rd_d = 5'd8; alucontrol_d = 3'b010;
    alusrc_d = 0; regdst_d = 1; regwrite_d = 1; memtoreg_d = 1; memwrite_d = 1; branch_d = 1;
    aluout_m = 0; writereg_m = 0; regwrite_m = 0;
    result_w = 0; writereg_w = 0; regwrite_w = 0;

    // Reset held across two edges with live decode inputs
    step(); step();
    check("rst_srca", srca_e, 32'h0);
    check("rst_srcb", srcb_e, 32'h0);
    check("rst_writereg", {27'b0, writereg_e}, 32'h0);
    check("rst_regwrite", {31'b0, regwrite_e}, 32'h0);
    check("rst_lwstall", {31'b0, lwstall}, 32'h0);
    check("rst_aluctl", {29'b0, alucontrol_e}, 32'h0);
    reset = 1'b1;

    // Plain pass-through
    rd1_d = 32'h5; rd2_d = 32'h3; alucontrol_d = 3'b010; alusrc_d = 0; regdst_d = 1;
    rd_d = 5'd8; memtoreg_d = 0; memwrite_d = 0; branch_d = 0;
    step();
    check("pass_srca", srca_e, 32'h5);
    check("pass_srcb", srcb_e, 32'h3);
    check("pass_aluctl", {29'b0, alucontrol_e}, 32'h2);
    check("pass_writereg", {27'b0, writereg_e}, 32'd8);
    check("pass_regwrite", {31'b0, regwrite_e}, 32'h1);
    check("pass_valid", {31'b0, valid_e}, 32'h1);
    alusrc_d = 1; signimm_d = 32'hFFFF_FFFC;
    step();
    check("imm_srcb", srcb_e, 32'hFFFF_FFFC);
    check("imm_srca", srca_e, 32'h5);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    check("arst_srca", srca_e, 32'h0);
    check("arst_srcb", srcb_e, 32'h0);
    check("arst_regwrite", {31'b0, regwrite_e}, 32'h0);
    check("arst_writereg", {27'b0, writereg_e}, 32'h0);
    reset = 1'b1;

    // Forwarding priority on A
    rs_d = 5'd9; rt_d = 5'd0; rd1_d = 32'h77; rd2_d = 32'h88; alusrc_d = 0;
    step();
    regwrite_m = 1; writereg_m = 5'd9; aluout_m = 32'hAAAA_0000;
    regwrite_w = 1; writereg_w = 5'd9; result_w = 32'h5555_0000;
    #1;
    check("fwd_mem_a", srca_e, 32'hAAAA_0000);
    check("fwd_b_untouched", srcb_e, 32'h88);
    regwrite_m = 0;
    #1;
    check("fwd_wb_a", srca_e, 32'h5555_0000);
    regwrite_m = 1; writereg_m = 0; writereg_w = 0;
    rs_d = 5'd0; rd1_d = 32'h123;
    step();
    check("fwd_r0_a", srca_e, 32'h123);

    // MEM forwarding on B
    rt_d = 5'd6; rd2_d = 32'h66; alusrc_d = 0;
    step();
    writereg_m = 5'd6; aluout_m = 32'hBEEF;
    #1;
    check("fwd_mem_b", srcb_e, 32'hBEEF);
    check("fwd_mem_wd", writedata_e, 32'hBEEF);

    // Store data forwarded from WB while srcb takes the immediate
    regwrite_m = 0; writereg_m = 0;
    rt_d = 5'd4; alusrc_d = 1; signimm_d = 32'h10; rd2_d = 32'h99;
    step();
    writereg_w = 5'd4; regwrite_w = 1; result_w = 32'h1234;
    #1;
    check("st_writedata", writedata_e, 32'h1234);
    check("st_srcb_imm", srcb_e, 32'h10);
    regwrite_w = 0; writereg_w = 0;

    // Stall holds instruction A, then stall+flush bubbles
    rd1_d = 32'hA1; rd2_d = 32'hA2; alusrc_d = 0; rs_d = 5'd10; rt_d = 5'd11; rd_d = 5'd12;
    regdst_d = 1; alucontrol_d = 3'b110; regwrite_d = 1; memwrite_d = 1; valid_d = 1;
    step();
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      rd1_d = 32'hB1 + i; rd2_d = 32'hB2 + i; rd_d = 5'd13; alucontrol_d = 3'b001;
      step();
      check("stall_srca", srca_e, 32'hA1);
      check("stall_srcb", srcb_e, 32'hA2);
      check("stall_writereg", {27'b0, writereg_e}, 32'd12);
      check("stall_aluctl", {29'b0, alucontrol_e}, 32'h6);
    end
    flush_e = 1;
    step();
    check("flush_regwrite", {31'b0, regwrite_e}, 32'h0);
    check("flush_memwrite", {31'b0, memwrite_e}, 32'h0);
    check("flush_valid", {31'b0, valid_e}, 32'h0);
    check("flush_srca", srca_e, 32'h0);
    stall_e = 0; flush_e = 0;

    // Load-use detection
    valid_d = 1; memtoreg_d = 1; regwrite_d = 1; memwrite_d = 0; regdst_d = 0;
    rt_d = 5'd7; rs_d = 5'd1; rd_d = 5'd0;
    step();
    check("lw_writereg", {27'b0, writereg_e}, 32'd7);
    rs_d = 5'd7; rt_d = 5'd2;
    #1;
    check("lw_rs_hit", {31'b0, lwstall}, 32'h1);
    rs_d = 5'd2; rt_d = 5'd7;
    #1;
    check("lw_rt_hit", {31'b0, lwstall}, 32'h1);
    rs_d = 5'd3; rt_d = 5'd3;
    #1;
    check("lw_miss", {31'b0, lwstall}, 32'h0);
    rs_d = 5'd7; valid_d = 0;
    #1;
    check("lw_decode_invalid", {31'b0, lwstall}, 32'h0);
    valid_d = 1; rt_d = 5'd0; rs_d = 5'd0;
    step();
    check("lw_r0", {31'b0, lwstall}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register plus forwarding and operand-select logic that drives the ALU's srca, srcb and alucontrol inputs.
- Captures decoded operands and control each cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and asks the hazard unit to stall decode.

Parameters:
- WIDTH, 32, datapath width of operands and results.
- REGW, 5, register-specifier width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears the stage.
- stall_e  in  1  hold all E registers this cycle.
- flush_e  in  1  load a bubble this cycle.
- valid_d  in  1  decode holds a real instruction.
- rd1_d, rd2_d  in  WIDTH  register-file read data.
- signimm_d  in  WIDTH  sign-extended immediate.
- rs_d, rt_d, rd_d  in  REGW  register specifiers.
- alucontrol_d  in  3  ALU op, same encoding as the ALU.
- alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d, branch_d  in  1 each  decode control.
- aluout_m  in  WIDTH  MEM-stage ALU result.
- writereg_m  in  REGW  MEM-stage destination register.
- regwrite_m  in  1  MEM-stage write enable.
- result_w  in  WIDTH  WB result.
- writereg_w  in  REGW  WB destination register.
- regwrite_w  in  1  WB write enable.
- srca_e, srcb_e  out  WIDTH  ALU operands.
- alucontrol_e  out  3  ALU op.
- writedata_e  out  WIDTH  forwarded rt value for stores.
- writereg_e  out  REGW  destination register.
- valid_e, regwrite_e, memtoreg_e, memwrite_e, branch_e  out  1 each  registered control.
- lwstall  out  1  load-use stall request to the hazard unit.

Behaviour:
- Registers: valid, rd1, rd2, signimm, rs, rt, rd, alucontrol, alusrc, regdst, regwrite, memtoreg, memwrite, branch (all _e).
- Reset = 0, asynchronous: every register clears to 0. Outputs then read: srca_e = 0, srcb_e = 0, alucontrol_e = 000, writereg_e = 0, all control outputs 0, lwstall = 0. Resetting mid-operation drops the in-flight instruction.
- Clock edge with reset = 1, priority flush_e > stall_e > load:
  - flush_e = 1: all registers cleared to 0, i.e. a bubble with regwrite/memwrite/branch = 0.
  - stall_e = 1 (no flush): every register holds its value.
  - Otherwise: every register loads its _d counterpart.
  - Latency: decode inputs are visible on E outputs 1 cycle later.
- Forwarding is combinational on the registered specifiers, applied to A (rs_e, rd1_e) and B (rt_e, rd2_e) independently:
  - MEM match: regwrite_m & writereg_m != 0 & writereg_m == rs_e (rt_e for B) selects aluout_m.
  - Else WB match: regwrite_w & writereg_w != 0 & writereg_w == rs_e (rt_e for B) selects result_w.
  - Else the registered read data is used.
  - MEM beats WB when both match. Register 0 is never forwarded.
- Output selection:
  - srca_e = forwarded A.
  - writedata_e = forwarded B.
  - srcb_e = alusrc_e ? signimm_e : forwarded B.
  - writereg_e = regdst_e ? rd_e : rt_e.
  - alucontrol_e = registered alucontrol.
- lwstall is combinational: valid_e & memtoreg_e & regwrite_e & writereg_e != 0 & valid_d & (rs_d == writereg_e | rt_d == writereg_e).
  - Expected system response: the hazard unit asserts stall on D/F and flush_e the same cycle. The stage itself does not act on lwstall.
- Simultaneous stall_e and flush_e: flush wins.
- Width rules: no arithmetic in this block. All muxes are WIDTH bits and nothing is truncated or extended.

Test Plan:
1. Reset: set reset = 0 for 2 cycles with non-zero _d inputs, then release -> srca_e = 0, srcb_e = 0, writereg_e = 0, regwrite_e = 0, lwstall = 0. Assert reset mid-stream -> outputs reach 0 asynchronously, before the next edge.
2. Plain pass: rd1_d = 0x0000_0005, rd2_d = 0x0000_0003, alucontrol_d = 010, alusrc_d = 0, regdst_d = 1, rd_d = 8, no forwarding -> next cycle srca_e = 5, srcb_e = 3, alucontrol_e = 010, writereg_e = 8. With alusrc_d = 1 and signimm_d = 0xFFFF_FFFC -> srcb_e = 0xFFFF_FFFC.
3. Forwarding priority:
   - rs_e = 9, regwrite_m = 1, writereg_m = 9, aluout_m = 0xAAAA_0000, regwrite_w = 1, writereg_w = 9, result_w = 0x5555_0000 -> srca_e = 0xAAAA_0000.
   - Drop regwrite_m -> srca_e = 0x5555_0000.
   - With writereg_m = writereg_w = 0 and rs_e = 0 -> srca_e = rd1_e.
4. Store data: rt_e = 4, alusrc_e = 1, writereg_w = 4, regwrite_w = 1, result_w = 0x1234 -> writedata_e = 0x1234, while srcb_e still equals signimm_e.
5. Stall/flush: load instruction A, then hold stall_e = 1 for 3 cycles while _d changes -> E outputs stay at A. Assert stall_e and flush_e together -> regwrite_e = 0, memwrite_e = 0, valid_e = 0 next cycle.
6. Load-use:
   - E holds lw with rt = 7 (memtoreg, regwrite, valid = 1, regdst = 0), decode rs_d = 7 -> lwstall = 1.
   - Decode rt_d = 7 instead -> lwstall = 1.
   - rs_d = rt_d = 3 -> lwstall = 0.
   - Load specifier 0 -> lwstall = 0.
